instruction_cache: RTL
======================

# instruction_cache

Direct-mapped, read-only instruction cache between the RV32IM pipeline's fetch stage and instruction memory. It accepts the fetch-stage PC and read enable, returns the 32-bit instruction on a hit in the same cycle, and stalls the whole pipeline via `BUSY_WAIT` while it fetches a 128-bit block from memory on a miss. It also supports a whole-cache invalidate (`FLUSH`) for `fence.i`.

## Interface
- `NUM_SETS`, default 8: number of cache lines. Power of two, 2..256. Block size is fixed at 4 words (128 bits).
- `CLK`  in  1  clock; all state updates on its rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `PC`  in  32  fetch address from the CPU. Bits [1:0] are ignored.
- `READ_EN`  in  1  fetch request from the CPU (`insReadEn`).
- `FLUSH`  in  1  invalidate all lines; single-cycle pulse.
- `INSTRUCTION`  out  32  fetched instruction. Valid only on a hit; 32'h0 otherwise.
- `BUSY_WAIT`  out  1  stall request to the CPU (`INS_CACHE_BUSY_WAIT`).
- `MEM_READ`  out  1  block read request to instruction memory.
- `MEM_ADDRESS`  out  28  block address to memory, equal to PC[31:4] of the missing fetch.
- `MEM_READ_DATA`  in  128  block returned by memory. Word 0 is in [31:0].
- `MEM_BUSY_WAIT`  in  1  high while memory is busy; low in the cycle `MEM_READ_DATA` is valid.

## Operation
- Address split (IDX_W = log2(NUM_SETS)):
  - offset = PC[3:2]
  - index = PC[4+IDX_W-1:4]
  - tag = PC[31:4+IDX_W] (25 bits at the default of 8 sets).
- Per-line storage: valid bit, tag, and 128-bit data.
- hit = READ_EN && valid[index] && tag match && state==IDLE. Hit is evaluated combinationally.
- `INSTRUCTION` = selected word when hit, else 32'h0. The pipeline treats 32'h0 as a bubble.
- `BUSY_WAIT` = (state==IDLE && READ_EN && !hit) || state!=IDLE.
- FSM has three states: IDLE, MEM_READ, UPDATE.
  - IDLE: on READ_EN && !hit, latch PC[31:4] into the miss-address register and go to MEM_READ. If READ_EN is low, stay in IDLE with no request.
  - MEM_READ: `MEM_READ`=1 and `MEM_ADDRESS`=latched address. When MEM_BUSY_WAIT==0, capture `MEM_READ_DATA` and go to UPDATE.
  - UPDATE: write the captured data, the latched tag and valid=1 into the latched index, then return to IDLE.
- After a fill, IDLE re-evaluates against the current PC. If the PC changed during the miss, a new miss starts; no stale word is ever returned.
- FLUSH:
  - In IDLE: clear all valid bits at that edge. That cycle's lookup still uses the pre-flush valid bits.
  - In MEM_READ or UPDATE: set a pending-flush flag. The fill completes, then all valid bits (including the just-filled line) are cleared on the first IDLE edge.
- Outside MEM_READ, `MEM_READ`=0 and `MEM_ADDRESS` holds its last value.

## Timing
- Reset values, asynchronous, applied while RESET=0:
  - state=IDLE, all valid bits=0, pending-flush=0, miss-address=0
  - `MEM_READ`=0, `MEM_ADDRESS`=0
  - `BUSY_WAIT`=0, `INSTRUCTION`=32'h0
- Reset during MEM_READ or UPDATE aborts the fill. `MEM_READ` drops immediately and no line is written.
- Hit latency: 0 cycles. `INSTRUCTION` and `BUSY_WAIT`=0 are valid combinationally within the same cycle as the PC.
- Miss timing, with memory taking L cycles (MEM_BUSY_WAIT low in the L-th MEM_READ cycle):
  - `BUSY_WAIT` is high for 1 + L + 1 cycles (IDLE detect, MEM_READ×L, UPDATE).
  - The hit appears in the following IDLE cycle.
- MEM_BUSY_WAIT is ignored outside MEM_READ.
- `MEM_READ_DATA` is sampled only at the edge where state==MEM_READ && MEM_BUSY_WAIT==0.
- PC=32'hFFFF_FFFC with READ_EN=0 (the CPU's reset PC) must not start a fill.
- Tag/data write and valid set occur at the same edge, at the end of UPDATE.

## Structure
- Package `icache_pkg` holds:
  - the state enum (IDLE, MEM_READ, UPDATE)
  - BLOCK_BITS=128, WORDS_PER_BLOCK=4, OFFSET_W=2
  - a function deriving tag width from NUM_SETS
- Single module; no sub-module. Arrays are inferred as registers because valid bits must clear asynchronously on reset and in a single cycle on flush.

## Test plan
- **Reset then cold miss:** release RESET, READ_EN=1, PC=0x0000_0000, memory L=3 returning 128'h0000_0013_00A0_0093_0050_0113_0000_0093 → `BUSY_WAIT` high for 5 cycles, `MEM_READ` high for 3 cycles with `MEM_ADDRESS`=0, then `INSTRUCTION`=32'h0000_0093 with `BUSY_WAIT`=0.
- **Same-block hits:** PC=0x4, 0x8, 0xC after the fill → 32'h0050_0113, 32'h00A0_0093, 32'h0000_0013, each with `BUSY_WAIT`=0 and `MEM_READ` never asserted.
- **Conflict miss:** PC=0x80 (same index 0, tag 1) → new fill with `MEM_ADDRESS`=28'h8. Returning to PC=0x0 then misses again.
- **Flush:** FLUSH pulse in IDLE → the next fetch at PC=0x0 misses. FLUSH pulsed during MEM_READ → after UPDATE the refetch of the same PC still misses.
- **Reset mid-fill:** RESET low during the 2nd MEM_READ cycle → `MEM_READ`=0 and `BUSY_WAIT`=0 immediately. After release, PC=0x0 misses.
- **READ_EN low:** PC=0xFFFF_FFFC with READ_EN=0 → `BUSY_WAIT`=0, `MEM_READ`=0, `INSTRUCTION`=32'h0.

Source files
------------

// File: rtl/instruction_cache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } icache_state_t;

    localparam int BLOCK_BITS      = 128;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_W        = 2;

    // Block address is PC[31:4]; the index takes the low bits, the tag the rest.
    function automatic int tag_width(input int num_sets);
        return 28 - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Block-read bus between the instruction cache (master) and instruction memory (slave).
interface instruction_cache_if;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READ_DATA;
    logic         MEM_BUSY_WAIT;

    modport master (
        output MEM_READ,
        output MEM_ADDRESS,
        input  MEM_READ_DATA,
        input  MEM_BUSY_WAIT
    );

    modport slave (
        input  MEM_READ,
        input  MEM_ADDRESS,
        output MEM_READ_DATA,
        output MEM_BUSY_WAIT
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, 4-word block fill on miss, fence.i flush.
//
// state    | meaning
// IDLE     | lookup; a miss latches the block address and starts a fill
// MEM_READ | block read outstanding; waits for MEM_BUSY_WAIT low
// UPDATE   | write captured block, tag and valid into the missing line
module instruction_cache
    import icache_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         PC,
    input  logic                READ_EN,
    input  logic                FLUSH,
    output logic [31:0]         INSTRUCTION,
    output logic                BUSY_WAIT,
    instruction_cache_if.master mem
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = tag_width(NUM_SETS);

    icache_state_t state, state_n;

    logic [NUM_SETS-1:0]   valid;
    logic [TAG_W-1:0]      tag_arr  [NUM_SETS];
    logic [BLOCK_BITS-1:0] data_arr [NUM_SETS];

    logic [27:0]           miss_addr;
    logic [BLOCK_BITS-1:0] fill_data;
    logic                  flush_pend;

    logic [OFFSET_W-1:0]   pc_off;
    logic [IDX_W-1:0]      pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic                  miss_start;
    logic                  unused_pc_bits;

    assign pc_off         = PC[3:2];
    assign pc_idx         = PC[4 +: IDX_W];
    assign pc_tag         = PC[31 -: TAG_W];
    assign fill_idx       = miss_addr[IDX_W-1:0];
    assign fill_tag       = miss_addr[27 -: TAG_W];
    assign unused_pc_bits = ^PC[1:0];

    // A pending flush makes every line look invalid so the just-filled line is never returned.
    assign hit = READ_EN && (state == IDLE) && !flush_pend &&
                 valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);

    assign miss_start  = (state == IDLE) && READ_EN && !hit;
    assign INSTRUCTION = hit ? data_arr[pc_idx][{pc_off, 5'b0} +: 32] : 32'h0;
    // Gated by RESET so the stall drops while reset is held even with READ_EN high.
    assign BUSY_WAIT   = RESET && (miss_start || (state != IDLE));

    assign mem.MEM_READ    = (state == MEM_READ);
    assign mem.MEM_ADDRESS = miss_addr;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (miss_start) state_n = MEM_READ;
            MEM_READ: if (!mem.MEM_BUSY_WAIT) state_n = UPDATE;
            UPDATE:   state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            valid      <= '0;
            flush_pend <= 1'b0;
            miss_addr  <= '0;
            fill_data  <= '0;
        end else begin
            state <= state_n;
            if (miss_start) miss_addr <= PC[31:4];
            if ((state == MEM_READ) && !mem.MEM_BUSY_WAIT) fill_data <= mem.MEM_READ_DATA;

            if (state == IDLE) begin
                flush_pend <= 1'b0;
                if (FLUSH || flush_pend) valid <= '0;
            end else begin
                if (FLUSH) flush_pend <= 1'b1;
                if (state == UPDATE) valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Line storage has no reset; only the valid bits gate its use.
    always_ff @(posedge CLK) begin
        if ((state == UPDATE) && RESET) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= fill_data;
        end
    end

endmodule
